rv_dbg_bridge: RTL and testbench
================================

Name: rv_dbg_bridge

Overview:
Serial debug/loader bridge and bus initiator on the rv_core data-bus protocol (adr/we/dw/re/dr/rdy), driven from a host over async serial at the opposite end of the link from rv_sio.
- Receives byte commands on rxd, executes 32-bit word reads/writes on the memory bus, and returns replies on txd.
- Holds the core in reset while a program is loaded into dpram.

Parameters:
DIV, 868, clock cycles per serial bit (100 MHz / 115200); legal range 4..65535
TMO_BYTES, 4, idle byte-times inside a partial command before it is discarded

Ports:
clk  input  1  system clock, all logic on rising edge
xreset  input  1  asynchronous active-low reset
rxd  input  1  serial in, idle high, 8N1 LSB first
txd  output  1  serial out, idle high, 8N1 LSB first
m_adr  output  32  bus address, word aligned (bits[1:0]=0)
m_we  output  4  byte write enables (4'hf or 0)
m_dw  output  32  bus write data
m_re  output  1  bus read enable
m_dr  input  32  bus read data
m_rdy  input  1  bus ready; request held while low
core_hold  output  1  held high keeps rv_core in reset

Behaviour:
- Reset (xreset low, async): txd=1, m_adr=0, m_we=0, m_dw=0, m_re=0, core_hold=1, FSM=IDLE, rx/tx shifters idle.
- RX: 2-FF synchronize rxd. Start bit is detected on a falling edge, re-checked at DIV/2 (glitch returns to idle), then 8 data bits sampled every DIV. Stop bit sampled; if 0, byte dropped (framing error). Valid byte -> 1-cycle rx_stb.
- TX: 1 start, 8 data, 1 stop, each DIV cycles; tx_busy high from load to end of stop bit.
- Commands (addr/data big-endian, 4 bytes each):
  - 'W'(0x57) a3 a2 a1 a0 d3 d2 d1 d0 -> bus write -> reply 'K'(0x4B)
  - 'R'(0x52) a3..a0 -> bus read -> reply d3 d2 d1 d0
  - 'H'(0x48) -> core_hold=1 -> reply 'K'
  - 'G'(0x47) -> core_hold=0 -> reply 'K'
  - Any other opcode in IDLE ignored; no reply.
- FSM states: IDLE, GETADR (4 bytes), GETDAT (4 bytes), BUSWR, BUSRD, RDWAIT, REPLY.
  - BUSWR: drive m_adr={a[31:2],2'b00}, m_dw, m_we=4'hf; hold until the cycle m_rdy=1; that is the single write cycle. Then m_we=0 -> REPLY.
  - BUSRD: m_re=1 held until m_rdy=1. Next cycle (RDWAIT) capture m_dr (1-cycle read latency, matching dpram) -> REPLY.
  - REPLY: queue 1 or 4 bytes; load each when !tx_busy; after last byte -> IDLE.
- Address bits[1:0] from the host are ignored (forced 0).
- Timeout: byte-time counter (10*DIV cycles) restarts on each rx_stb. In GETADR/GETDAT, TMO_BYTES byte-times without a byte -> IDLE, no reply, no bus access.
- Bytes arriving during BUSWR/BUSRD/RDWAIT/REPLY are discarded (host must wait for reply).
- m_we and m_re are never both nonzero; at most one bus request outstanding.
- Async reset mid-transfer: bus strobes drop immediately; txd returns high (partial byte truncated).

Decomposition:
- Shared package (rv_types): opcode constants CMD_W/CMD_R/CMD_H/CMD_G/RSP_K, FSM state enum type, existing u32_t/u8_t/u4_t.
- Sub-module rv_dbg_uart: RX + TX shifters parameterized by DIV. Interface: rx_stb/rx_data, tx_load/tx_data/tx_busy. The parent holds the command FSM and bus logic.

Test Plan:
- Reset then idle: txd=1, core_hold=1, m_we=0, m_re=0 for 100 cycles.
- Send 'W' 00 00 01 04 DE AD BE EF with m_rdy=1 -> exactly one cycle m_we=4'hf, m_adr=0x104, m_dw=0xDEADBEEF, then 'K' (0x4B) serialized on txd.
- Write as above with m_rdy held low 5 cycles -> request held stable 6 cycles, single accepted write, 'K' reply.
- Send 'R' 00 00 01 07 with model returning 0x12345678 one cycle after m_re -> m_adr=0x104, reply bytes 12 34 56 78 in order.
- Send 'G' -> core_hold falls, 'K'. Send 'H' -> core_hold rises, 'K'. Send 0x00 -> no reply, no bus activity.
- Send 'W' 00 00 then silence for >4 byte-times, then 'R' 00 00 00 00 -> first command dropped with no write; read of address 0 executes normally. Separately, a byte with stop bit=0 is dropped.

Source files
------------

// File: rtl/rv_types.sv
// Shared types and constants for the serial debug bridge.
package rv_types;

  typedef logic [31:0] u32_t;
  typedef logic [7:0]  u8_t;
  typedef logic [3:0]  u4_t;

  // Host command opcodes and the acknowledge reply
  localparam u8_t CMD_W = 8'h57;
  localparam u8_t CMD_R = 8'h52;
  localparam u8_t CMD_H = 8'h48;
  localparam u8_t CMD_G = 8'h47;
  localparam u8_t RSP_K = 8'h4B;

  // Width of the per-bit cycle counters (DIV up to 65535)
  localparam int unsigned DIV_W = 16;

  // Command FSM
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GETADR,
    ST_GETDAT,
    ST_BUSWR,
    ST_BUSRD,
    ST_RDWAIT,
    ST_REPLY
  } dbg_st_t;

  // Serial receiver / transmitter FSMs
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_st_t;

  typedef enum logic {
    TX_IDLE,
    TX_RUN
  } tx_st_t;

  // Registered bus request payload
  typedef struct packed {
    u32_t adr;
    u4_t  we;
    u32_t dw;
    logic re;
  } bus_req_t;

endpackage

// File: rtl/rv_dbg_uart.sv
// 8N1 serial receiver and transmitter, DIV clocks per bit.
module rv_dbg_uart
  import rv_types::*;
#(
  parameter int unsigned DIV = 868
) (
  input  logic       clk,
  input  logic       xreset,
  input  logic       rxd,
  output logic       txd,
  output logic       rx_stb,
  output logic [7:0] rx_data,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  output logic       tx_busy
);

  localparam logic [DIV_W-1:0] BIT_LAST  = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(DIV / 2 - 1);

  logic             rx_s1, rx_cur, rx_prev;
  rx_st_t           rx_st, rx_st_d;
  logic [DIV_W-1:0] rx_cnt, rx_cnt_d;
  logic [2:0]       rx_bit, rx_bit_d;
  logic [7:0]       rx_sh, rx_sh_d;
  logic             rx_stb_d;
  logic [7:0]       rx_data_d;

  tx_st_t           tx_st, tx_st_d;
  logic [DIV_W-1:0] tx_cnt, tx_cnt_d;
  logic [3:0]       tx_bit, tx_bit_d;
  logic [9:0]       tx_sh, tx_sh_d;
  logic             txd_d, tx_busy_d;

  // Two-flop synchronizer plus one delayed copy for falling-edge detect
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      rx_s1   <= 1'b1;
      rx_cur  <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_cur  <= rx_s1;
      rx_prev <= rx_cur;
    end
  end

  // Receiver state register
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      rx_st   <= RX_IDLE;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_stb  <= 1'b0;
      rx_data <= '0;
    end else begin
      rx_st   <= rx_st_d;
      rx_cnt  <= rx_cnt_d;
      rx_bit  <= rx_bit_d;
      rx_sh   <= rx_sh_d;
      rx_stb  <= rx_stb_d;
      rx_data <= rx_data_d;
    end
  end

  // Receiver next state: mid-start recheck, then mid-bit sampling
  always_comb begin
    rx_st_d   = rx_st;
    rx_cnt_d  = rx_cnt + DIV_W'(1);
    rx_bit_d  = rx_bit;
    rx_sh_d   = rx_sh;
    rx_stb_d  = 1'b0;
    rx_data_d = rx_data;
    case (rx_st)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev && !rx_cur) rx_st_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_cur ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_cur, rx_sh[7:1]};
          rx_bit_d = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_st_d  = RX_IDLE;
          if (rx_cur) begin
            rx_stb_d  = 1'b1;
            rx_data_d = rx_sh;
          end
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // Transmitter state register
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      tx_st   <= TX_IDLE;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '1;
      txd     <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      tx_st   <= tx_st_d;
      tx_cnt  <= tx_cnt_d;
      tx_bit  <= tx_bit_d;
      tx_sh   <= tx_sh_d;
      txd     <= txd_d;
      tx_busy <= tx_busy_d;
    end
  end

  // Transmitter next state: frame is {stop, data, start} shifted out LSB first
  always_comb begin
    tx_st_d   = tx_st;
    tx_cnt_d  = tx_cnt;
    tx_bit_d  = tx_bit;
    tx_sh_d   = tx_sh;
    txd_d     = txd;
    tx_busy_d = tx_busy;
    case (tx_st)
      TX_IDLE: begin
        txd_d     = 1'b1;
        tx_busy_d = 1'b0;
        if (tx_load) begin
          tx_sh_d   = {1'b1, tx_data, 1'b0};
          txd_d     = 1'b0;
          tx_cnt_d  = '0;
          tx_bit_d  = '0;
          tx_busy_d = 1'b1;
          tx_st_d   = TX_RUN;
        end
      end
      TX_RUN: begin
        tx_cnt_d = tx_cnt + DIV_W'(1);
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit == 4'd9) begin
            tx_st_d   = TX_IDLE;
            tx_busy_d = 1'b0;
            txd_d     = 1'b1;
          end else begin
            tx_bit_d = tx_bit + 4'd1;
            tx_sh_d  = {1'b1, tx_sh[9:1]};
            txd_d    = tx_sh[1];
          end
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/rv_dbg_bridge.sv
// Serial debug/loader bridge: host byte commands become bus reads/writes.
module rv_dbg_bridge
  import rv_types::*;
#(
  parameter int unsigned DIV       = 868,
  parameter int unsigned TMO_BYTES = 4
) (
  input  logic        clk,
  input  logic        xreset,
  input  logic        rxd,
  output logic        txd,
  output logic [31:0] m_adr,
  output logic [3:0]  m_we,
  output logic [31:0] m_dw,
  output logic        m_re,
  input  logic [31:0] m_dr,
  input  logic        m_rdy,
  output logic        core_hold
);

  localparam int unsigned BT_W = 20;
  localparam int unsigned TB_W = 8;
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(10 * DIV - 1);
  localparam logic [TB_W-1:0] TMO_LIM = TB_W'(TMO_BYTES);

  logic       rx_stb, tx_busy;
  logic [7:0] rx_data;

  logic [BT_W-1:0] bt_cnt;
  logic [TB_W-1:0] bt_n;
  logic            tmo_c;

  dbg_st_t  st, st_d;
  u8_t      op, op_d;
  logic [1:0] idx, idx_d;
  u32_t     adr, adr_d, dat, dat_d, rsp, rsp_d;
  logic [2:0] rsp_n, rsp_n_d;
  bus_req_t bus, bus_d;
  logic     hold_q, hold_d;
  logic     tx_load_q, tx_load_d;
  u8_t      tx_data_q, tx_data_d;

  rv_dbg_uart #(.DIV(DIV)) u_uart (
    .clk     (clk),
    .xreset  (xreset),
    .rxd     (rxd),
    .txd     (txd),
    .rx_stb  (rx_stb),
    .rx_data (rx_data),
    .tx_load (tx_load_q),
    .tx_data (tx_data_q),
    .tx_busy (tx_busy)
  );

  assign m_adr     = bus.adr;
  assign m_we      = bus.we;
  assign m_dw      = bus.dw;
  assign m_re      = bus.re;
  assign core_hold = hold_q;

  // Byte-time counter; counts idle byte-times since the last received byte
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      bt_cnt <= '0;
      bt_n   <= '0;
    end else if (rx_stb) begin
      bt_cnt <= '0;
      bt_n   <= '0;
    end else if (bt_cnt == BT_LAST) begin
      bt_cnt <= '0;
      if (bt_n != TMO_LIM) bt_n <= bt_n + TB_W'(1);
    end else begin
      bt_cnt <= bt_cnt + BT_W'(1);
    end
  end

  assign tmo_c = (bt_n == TMO_LIM);

  // Command FSM state register
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      st        <= ST_IDLE;
      op        <= '0;
      idx       <= '0;
      adr       <= '0;
      dat       <= '0;
      rsp       <= '0;
      rsp_n     <= '0;
      bus       <= '0;
      hold_q    <= 1'b1;
      tx_load_q <= 1'b0;
      tx_data_q <= '0;
    end else begin
      st        <= st_d;
      op        <= op_d;
      idx       <= idx_d;
      adr       <= adr_d;
      dat       <= dat_d;
      rsp       <= rsp_d;
      rsp_n     <= rsp_n_d;
      bus       <= bus_d;
      hold_q    <= hold_d;
      tx_load_q <= tx_load_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Command FSM next state: parse bytes, run one bus access, queue reply
  always_comb begin
    st_d      = st;
    op_d      = op;
    idx_d     = idx;
    adr_d     = adr;
    dat_d     = dat;
    rsp_d     = rsp;
    rsp_n_d   = rsp_n;
    bus_d     = bus;
    hold_d    = hold_q;
    tx_load_d = 1'b0;
    tx_data_d = tx_data_q;
    case (st)
      ST_IDLE: begin
        if (rx_stb) begin
          case (rx_data)
            CMD_W, CMD_R: begin
              op_d  = rx_data;
              idx_d = '0;
              st_d  = ST_GETADR;
            end
            CMD_H, CMD_G: begin
              hold_d  = (rx_data == CMD_H);
              rsp_d   = {RSP_K, 24'h0};
              rsp_n_d = 3'd1;
              st_d    = ST_REPLY;
            end
            default: ;
          endcase
        end
      end
      ST_GETADR: begin
        if (rx_stb) begin
          adr_d = {adr[23:0], rx_data};
          idx_d = idx + 2'd1;
          if (idx == 2'd3) begin
            if (op == CMD_W) begin
              st_d = ST_GETDAT;
            end else begin
              bus_d.adr = {adr[23:0], rx_data[7:2], 2'b00};
              bus_d.re  = 1'b1;
              st_d      = ST_BUSRD;
            end
          end
        end else if (tmo_c) begin
          st_d = ST_IDLE;
        end
      end
      ST_GETDAT: begin
        if (rx_stb) begin
          dat_d = {dat[23:0], rx_data};
          idx_d = idx + 2'd1;
          if (idx == 2'd3) begin
            bus_d.adr = {adr[31:2], 2'b00};
            bus_d.dw  = {dat[23:0], rx_data};
            bus_d.we  = 4'hf;
            st_d      = ST_BUSWR;
          end
        end else if (tmo_c) begin
          st_d = ST_IDLE;
        end
      end
      ST_BUSWR: begin
        if (m_rdy) begin
          bus_d.we = 4'h0;
          rsp_d    = {RSP_K, 24'h0};
          rsp_n_d  = 3'd1;
          st_d     = ST_REPLY;
        end
      end
      ST_BUSRD: begin
        if (m_rdy) begin
          bus_d.re = 1'b0;
          st_d     = ST_RDWAIT;
        end
      end
      ST_RDWAIT: begin
        rsp_d   = m_dr;
        rsp_n_d = 3'd4;
        st_d    = ST_REPLY;
      end
      ST_REPLY: begin
        // tx_busy rises one cycle after a load, so skip the cycle right after one
        if (!tx_busy && !tx_load_q) begin
          tx_load_d = 1'b1;
          tx_data_d = rsp[31:24];
          rsp_d     = {rsp[23:0], 8'h00};
          rsp_n_d   = rsp_n - 3'd1;
          if (rsp_n == 3'd1) st_d = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rv_dbg_bridge.sv
// Scoreboard bench for rv_dbg_bridge: host serial driver, bus responder, reply decoder.
module tb_rv_dbg_bridge;

  localparam int unsigned DIV       = 10;
  localparam int unsigned TMO_BYTES = 4;
  localparam int unsigned BYTE_CYC  = 10 * DIV;

  logic        clk = 1'b0;
  logic        xreset = 1'b0;
  logic        rxd = 1'b1;
  logic        txd;
  logic [31:0] m_adr, m_dw;
  logic [3:0]  m_we;
  logic        m_re;
  logic [31:0] m_dr = 32'h0;
  logic        m_rdy = 1'b0;
  logic        core_hold;

  always #5 clk = ~clk;

  rv_dbg_bridge #(.DIV(DIV), .TMO_BYTES(TMO_BYTES)) dut (
    .clk       (clk),
    .xreset    (xreset),
    .rxd       (rxd),
    .txd       (txd),
    .m_adr     (m_adr),
    .m_we      (m_we),
    .m_dw      (m_dw),
    .m_re      (m_re),
    .m_dr      (m_dr),
    .m_rdy     (m_rdy),
    .core_hold (core_hold)
  );

  int n_chk = 0;
  int n_err = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void note_fail(string name, logic [31:0] act);
    n_chk++;
    n_err++;
    $display("FAIL %s: got 0x%08h with nothing expected at %0t", name, act, $time);
  endfunction

  // Scoreboard queues and reference memory
  typedef struct {
    bit          wr;
    logic [31:0] adr;
    logic [31:0] dw;
  } bus_exp_t;

  logic [7:0]  exp_tx[$];
  bus_exp_t    exp_bus[$];
  logic [31:0] mdl_mem[logic [31:0]];
  logic [31:0] resp_mem[logic [31:0]];
  bit          exp_hold = 1'b1;

  function automatic logic [31:0] def_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] mdl_rd(logic [31:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : def_word(a);
  endfunction

  function automatic logic [31:0] resp_rd(logic [31:0] a);
    return resp_mem.exists(a) ? resp_mem[a] : def_word(a);
  endfunction

  // Bus responder and monitor: stalls m_rdy, returns read data one cycle after acceptance
  logic        l_req = 1'b0, l_rdy = 1'b0, l_re = 1'b0;
  logic [3:0]  l_we = 4'h0;
  logic [31:0] l_adr = 32'h0, l_dw = 32'h0;
  int          held = 0, req_stall = 0, stall_cfg = 0;
  bit          rand_stall = 1'b0, stable = 1'b1, overlap = 1'b0;

  always @(negedge clk) begin : bus_mon
    bus_exp_t e;
    logic     cur_req;
    cur_req = (m_we != 4'h0) || m_re;
    if ((m_we != 4'h0) && m_re) overlap = 1'b1;
    m_dr = $urandom();
    if (l_req && l_rdy) begin
      if (exp_bus.size() == 0) begin
        note_fail("bus_unexpected_txn", l_adr);
      end else begin
        e = exp_bus.pop_front();
        check("bus_we", 32'(l_we), e.wr ? 32'hf : 32'h0);
        check("bus_re", 32'(l_re), e.wr ? 32'h0 : 32'h1);
        check("bus_adr", l_adr, e.adr);
        if (e.wr) check("bus_dw", l_dw, e.dw);
        check("bus_hold_cycles", 32'(held), 32'(req_stall + 1));
        check("bus_req_stable", 32'(stable), 32'h1);
        check("bus_we_re_overlap", 32'(overlap), 32'h0);
      end
      if (l_we != 4'h0) resp_mem[l_adr] = l_dw;
      else m_dr = resp_rd(l_adr);
      held   = 0;
      stable = 1'b1;
    end else if (l_req && (l_adr != m_adr || l_we != m_we || l_dw != m_dw || l_re != m_re)) begin
      stable = 1'b0;
    end
    if (cur_req) begin
      if (held == 0) req_stall = rand_stall ? int'($urandom_range(0, 3)) : stall_cfg;
      held++;
      m_rdy = (held > req_stall);
    end else begin
      m_rdy = 1'b0;
    end
    l_req = cur_req;
    l_rdy = m_rdy;
    l_adr = m_adr;
    l_we  = m_we;
    l_dw  = m_dw;
    l_re  = m_re;
  end

  // Reply decoder: samples txd mid-bit and compares against queued bytes
  always begin : tx_mon
    logic [7:0] b;
    logic       sb, pb;
    @(negedge clk);
    if (xreset && txd === 1'b0) begin
      repeat (DIV / 2) @(negedge clk);
      sb = txd;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = txd;
      end
      repeat (DIV) @(negedge clk);
      pb = txd;
      if (exp_tx.size() == 0) begin
        note_fail("tx_unexpected_byte", 32'(b));
      end else begin
        check("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
        check("tx_start_bit", 32'(sb), 32'h0);
        check("tx_stop_bit", 32'(pb), 32'h1);
      end
    end
  end

  // Host side: one 8N1 frame, optionally with a bad stop bit
  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop_ok;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic cmd_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] aw;
    aw = {a[31:2], 2'b00};
    exp_bus.push_back('{1'b1, aw, d});
    mdl_mem[aw] = d;
    exp_tx.push_back(8'h4B);
    send_byte(8'h57);
    send_word(a);
    send_word(d);
  endtask

  task automatic cmd_read(input logic [31:0] a);
    logic [31:0] aw, w;
    aw = {a[31:2], 2'b00};
    w  = mdl_rd(aw);
    exp_bus.push_back('{1'b0, aw, 32'h0});
    for (int i = 3; i >= 0; i--) exp_tx.push_back(w[8*i +: 8]);
    send_byte(8'h52);
    send_word(a);
  endtask

  task automatic cmd_hold(input bit h);
    exp_hold = h;
    exp_tx.push_back(8'h4B);
    send_byte(h ? 8'h48 : 8'h47);
  endtask

  // Bounded wait for all expectations to drain
  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && (exp_tx.size() != 0 || exp_bus.size() != 0); i++)
      @(negedge clk);
    check("pending_expectations", 32'(exp_tx.size() + exp_bus.size()), 32'h0);
    exp_tx.delete();
    exp_bus.delete();
    repeat (20) @(negedge clk);
  endtask

  initial begin : watchdog
    repeat (95000) @(negedge clk);
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog expired");
  end

  logic [31:0] pool [4] = '{32'h0000_0000, 32'h0000_0104, 32'h0000_2000, 32'hFFFF_FFFC};

  initial begin : stim
    logic [7:0]  jb;
    logic [31:0] a;
    int          k;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'h1);
    check("rst_hold", 32'(core_hold), 32'h1);
    check("rst_adr", m_adr, 32'h0);
    check("rst_dw", m_dw, 32'h0);
    xreset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_txd", 32'(txd), 32'h1);
      check("idle_hold", 32'(core_hold), 32'h1);
      check("idle_we", 32'(m_we), 32'h0);
      check("idle_re", 32'(m_re), 32'h0);
    end

    // Single write, bus ready immediately
    stall_cfg = 0;
    cmd_write(32'h0000_0104, 32'hDEAD_BEEF);
    wait_done(3000);

    // Same write with the bus stalled five cycles
    stall_cfg = 5;
    cmd_write(32'h0000_0104, 32'hDEAD_BEEF);
    wait_done(3000);

    // Read with unaligned host address
    stall_cfg = 0;
    mdl_mem[32'h104]  = 32'h1234_5678;
    resp_mem[32'h104] = 32'h1234_5678;
    cmd_read(32'h0000_0107);
    wait_done(3000);

    // Core hold release and re-assert
    cmd_hold(1'b0);
    wait_done(3000);
    check("core_hold_go", 32'(core_hold), 32'(exp_hold));
    cmd_hold(1'b1);
    wait_done(3000);
    check("core_hold_halt", 32'(core_hold), 32'(exp_hold));
    cmd_hold(1'b0);
    wait_done(3000);

    // Unknown opcode: nothing happens
    send_byte(8'h00);
    repeat (3 * BYTE_CYC) @(negedge clk);
    check("junk_hold", 32'(core_hold), 32'(exp_hold));

    // Partial write abandoned by timeout, then a normal read
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat ((TMO_BYTES + 2) * BYTE_CYC) @(negedge clk);
    cmd_read(32'h0000_0000);
    wait_done(3000);

    // Framing error: 'H' with stop bit low must be dropped
    send_byte(8'h48, 1'b0);
    repeat (3 * BYTE_CYC) @(negedge clk);
    check("framing_hold", 32'(core_hold), 32'(exp_hold));
    cmd_read(32'h0000_0104);
    wait_done(3000);

    // Randomized command mix with random bus stalls
    rand_stall = 1'b1;
    for (int n = 0; n < 24; n++) begin
      k = int'($urandom_range(0, 8));
      a = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      if (k <= 2) begin
        cmd_write(a, $urandom());
        wait_done(3000);
      end else if (k <= 5) begin
        cmd_read(a);
        wait_done(3000);
      end else if (k <= 7) begin
        cmd_hold(1'($urandom_range(0, 1)));
        wait_done(3000);
        check("rand_hold", 32'(core_hold), 32'(exp_hold));
      end else begin
        jb = 8'($urandom());
        if (jb == 8'h57 || jb == 8'h52 || jb == 8'h48 || jb == 8'h47) jb = 8'hA5;
        send_byte(jb);
        repeat (3 * BYTE_CYC) @(negedge clk);
        check("rand_junk_hold", 32'(core_hold), 32'(exp_hold));
      end
    end

    repeat (2 * BYTE_CYC) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
